sample_merge: RTL and testbench
===============================

// Module: sample_merge
// PURPOSE
// - Producer side of the FIR sample interface: assembles the ADC byte stream into signed WIDTH-bit samples.
// - Issues a one-cycle merge_finished_o pulse per sample; this pulse qualifies the sample for the downstream low-pass FIR.
// - Enforces frame sync (SYNC_BYTE, then FRAME_LEN byte pairs) and an inter-byte timeout.
// - Bad framing never reaches the filter.
// PARAMETERS
// - WIDTH      16    output sample width; fixed at 16 (two bytes); any other value is a config error
// - FRAME_LEN  64    samples (byte pairs) per frame between sync bytes; range 1..65535
// - SYNC_BYTE  8'hA5 frame header byte
// - MSB_FIRST  1     1: first byte of a pair is the high byte; 0: low byte first
// - OFFSET_BIN 1     1: input is offset binary, so invert the sample MSB to get two's complement; 0: pass through
// - TIMEOUT    255   max idle cycles between the two bytes of a pair; range 1..2^16-1
// PORTS
// - clk               in   1      system clock
// - rst               in   1      synchronous, active-high reset
// - start_i           in   1      global run enable (same signal the FIR sees); low = idle and flush
// - byte_i            in   8      ADC byte
// - byte_valid_i      in   1      byte_i valid this cycle; no backpressure, every valid byte is consumed
// - data_o            out  WIDTH  signed merged sample; held between pulses
// - merge_finished_o  out  1      one-cycle pulse: data_o is new this cycle
// - in_sync_o         out  1      high while in states LO/HI
// - err_cnt_o         out  16     saturating count of framing and timeout errors
// BEHAVIOUR
// Clock and reset
// - One clock; reset is synchronous and active-high.
// - Reset values: data_o=0, merge_finished_o=0, in_sync_o=0, err_cnt_o=0, state=IDLE, all counters 0.
// - Reset mid-pair or mid-frame discards all partial state.
// State machine
// - IDLE: entered when start_i=0, from any state, and partial bytes are discarded. Goes to HUNT when start_i=1.
// - HUNT: valid byte == SYNC_BYTE -> LO with sample count=0. Any other byte is dropped, with no error.
// - LO: a valid byte is latched as the first byte -> HI, and the timeout counter is cleared.
// - HI:
//   - A valid byte completes the pair.
//   - Next cycle: data_o is updated and merge_finished_o=1. Latency is 1 clk from the second byte to the pulse.
//   - Sample count increments. If count==FRAME_LEN -> CHK, else -> LO.
//   - No valid byte for TIMEOUT consecutive cycles -> HUNT, with err_cnt_o+1 and the pair discarded.
// - CHK:
//   - Valid byte == SYNC_BYTE -> LO with count=0.
//   - Any other byte -> HUNT with err_cnt_o+1, and that byte is not rechecked as sync.
// Arithmetic
// - Assembled sample: raw = MSB_FIRST ? {first,second} : {second,first}.
// - data_o = OFFSET_BIN ? {~raw[15], raw[14:0]} : raw.
// - No rounding or saturation is needed.
// Boundary conditions
// - err_cnt_o saturates at 16'hFFFF.
// - The timeout counter runs only in HI and never wraps (it compares before incrementing).
// - byte_valid_i on the same cycle as a merge_finished_o pulse is accepted normally; back-to-back bytes every clock are supported.
// - merge_finished_o is never high on two consecutive cycles, and never high while start_i=0.
// - start_i falling on the same cycle as the second byte: the sample is dropped and no pulse is issued.
// - Sync detection in HUNT uses only the current byte (no lookahead). A data byte equal to SYNC_BYTE inside a frame is plain data.
// STRUCTURE
// - Shared package fm_demod_pkg:
//   - SYNC_BYTE default
//   - sample width constant (16)
//   - state encoding IDLE/HUNT/LO/HI/CHK (3-bit)
//   - err counter width
// - One sub-module, merge_timeout_cnt (clear, enable, TIMEOUT compare, expired flag), is natural.
// - Everything else stays in a single registered FSM plus the assembly datapath.
// TESTING
// - Reset, start_i=1, bytes A5,12,34 (MSB_FIRST=1, OFFSET_BIN=0) -> one pulse 1 clk after 0x34; data_o=16'h1234.
// - OFFSET_BIN=1, pair 80,00 -> data_o=16'h0000; pair FF,FF -> 16'h7FFF; pair 00,00 -> 16'h8000.
// - FRAME_LEN=2: A5,(2 pairs),A5,(1 pair) -> 3 pulses, err_cnt_o=0.
//   - Same stream with the second A5 replaced by 5A -> 2 pulses, err_cnt_o=1, in_sync_o=0 until the next A5.
// - TIMEOUT=4: A5, byte 11, then 4 idle cycles, then 22 -> no pulse, err_cnt_o=1; 22 is dropped in HUNT.
// - Bytes on every clock (A5 then 8 data bytes) -> 4 pulses exactly 2 clk apart; merge_finished_o is never on adjacent cycles.
// - Deassert start_i, or pulse rst, between the two bytes of a pair -> no pulse; state returns to IDLE; data_o keeps its last value (rst: 0).

Source files
------------

// File: rtl/fm_demod_pkg.sv
// Shared constants and state encoding for the ADC byte-to-sample merge path.
// Imported by the merge FSM and its timeout counter.
package fm_demod_pkg;

    localparam int          SAMPLE_W      = 16;
    localparam int          ERR_W         = 16;
    localparam int          CNT_W         = 16;
    localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HUNT = 3'd1,
        ST_LO   = 3'd2,
        ST_HI   = 3'd3,
        ST_CHK  = 3'd4
    } state_e;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (v == {ERR_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/merge_timeout_cnt.sv
// Idle-cycle counter for the gap between the two bytes of a pair.
// Compares before incrementing, so it stops at TIMEOUT-1 and never wraps.
module merge_timeout_cnt
    import fm_demod_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hit;

    assign hit       = (cnt_q == CNT_W'(TIMEOUT - 1));
    assign expired_o = en_i && hit;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i && !hit)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/sample_merge.sv
// Frames the ADC byte stream into signed 16-bit samples for the low-pass FIR.
// merge_finished_o qualifies data_o; malformed frames only bump err_cnt_o.
module sample_merge
    import fm_demod_pkg::*;
#(
    parameter int         WIDTH      = SAMPLE_W,
    parameter int         FRAME_LEN  = 64,
    parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEF,
    parameter bit         MSB_FIRST  = 1'b1,
    parameter bit         OFFSET_BIN = 1'b1,
    parameter int         TIMEOUT    = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [7:0]       byte_i,
    input  logic             byte_valid_i,
    output logic [WIDTH-1:0] data_o,
    output logic             merge_finished_o,
    output logic             in_sync_o,
    output logic [ERR_W-1:0] err_cnt_o
);

    if (WIDTH != SAMPLE_W) begin : g_bad_width
        $error("sample_merge: WIDTH must be 16");
    end

    state_e                state_q, state_d;
    logic [7:0]            first_q, first_d;
    logic [SAMPLE_W-1:0]   data_q, data_d;
    logic                  pulse_q, pulse_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ERR_W-1:0]      err_q, err_d;
    logic [CNT_W:0]        cnt_inc;
    logic [SAMPLE_W-1:0]   raw;
    logic                  is_sync;
    logic                  err_inc;
    logic                  tmo_clr, tmo_en, tmo_expired;

    merge_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (tmo_clr),
        .en_i     (tmo_en),
        .expired_o(tmo_expired)
    );

    assign is_sync = byte_valid_i && (byte_i == SYNC_BYTE);
    assign cnt_inc = {1'b0, cnt_q} + 1'b1;
    assign raw     = MSB_FIRST ? {first_q, byte_i} : {byte_i, first_q};
    // Idle cycles only count while a pair is half-assembled and the run is on.
    assign tmo_en  = start_i && (state_q == ST_HI) && !byte_valid_i;

    always_comb begin
        state_d = state_q;
        first_d = first_q;
        data_d  = data_q;
        pulse_d = 1'b0;
        cnt_d   = cnt_q;
        err_inc = 1'b0;
        tmo_clr = 1'b0;
        if (!start_i) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: state_d = ST_HUNT;
                ST_HUNT: begin
                    if (is_sync) begin
                        state_d = ST_LO;
                        cnt_d   = '0;
                    end
                end
                ST_LO: begin
                    if (byte_valid_i) begin
                        first_d = byte_i;
                        tmo_clr = 1'b1;
                        state_d = ST_HI;
                    end
                end
                ST_HI: begin
                    if (byte_valid_i) begin
                        data_d  = OFFSET_BIN ? {~raw[SAMPLE_W-1], raw[SAMPLE_W-2:0]} : raw;
                        pulse_d = 1'b1;
                        cnt_d   = cnt_inc[CNT_W-1:0];
                        state_d = (cnt_inc == (CNT_W+1)'(FRAME_LEN)) ? ST_CHK : ST_LO;
                    end else if (tmo_expired) begin
                        err_inc = 1'b1;
                        state_d = ST_HUNT;
                    end
                end
                ST_CHK: begin
                    if (is_sync) begin
                        state_d = ST_LO;
                        cnt_d   = '0;
                    end else if (byte_valid_i) begin
                        err_inc = 1'b1;
                        state_d = ST_HUNT;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        err_d = err_inc ? sat_inc(err_q) : err_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            first_q <= '0;
            data_q  <= '0;
            pulse_q <= 1'b0;
            cnt_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            first_q <= first_d;
            data_q  <= data_d;
            pulse_q <= pulse_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // The FIR shares start_i, so a pulse must never appear while it is low.
    assign merge_finished_o = pulse_q && start_i;
    assign data_o           = data_q;
    assign in_sync_o        = (state_q == ST_LO) || (state_q == ST_HI);
    assign err_cnt_o        = err_q;

endmodule

// File: tb/tb_sample_merge.sv
// Drives three differently configured sample_merge instances with one byte stream
// and checks them every cycle against a frame-level model, plus fixed scenarios.
module tb_sample_merge;

    localparam int ND = 3;
    localparam int FL   [ND] = '{2, 3, 64};
    localparam int TO   [ND] = '{4, 5, 255};
    localparam bit MSBF [ND] = '{1'b1, 1'b1, 1'b0};
    localparam bit OB   [ND] = '{1'b0, 1'b1, 1'b0};

    localparam int M_IDLE = 0, M_HUNT = 1, M_FRAME = 2, M_CHK = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_i = 1'b0;
    logic [7:0] byte_i = 8'h00;
    logic byte_valid_i = 1'b0;

    logic [ND-1:0][15:0] data_w;
    logic [ND-1:0]       fin_w;
    logic [ND-1:0]       sync_w;
    logic [ND-1:0][15:0] err_w;

    always #5 clk = ~clk;

    sample_merge #(.FRAME_LEN(2), .TIMEOUT(4), .MSB_FIRST(1'b1), .OFFSET_BIN(1'b0)) u0 (
        .clk(clk), .rst(rst), .start_i(start_i), .byte_i(byte_i), .byte_valid_i(byte_valid_i),
        .data_o(data_w[0]), .merge_finished_o(fin_w[0]), .in_sync_o(sync_w[0]), .err_cnt_o(err_w[0]));
    sample_merge #(.FRAME_LEN(3), .TIMEOUT(5), .MSB_FIRST(1'b1), .OFFSET_BIN(1'b1)) u1 (
        .clk(clk), .rst(rst), .start_i(start_i), .byte_i(byte_i), .byte_valid_i(byte_valid_i),
        .data_o(data_w[1]), .merge_finished_o(fin_w[1]), .in_sync_o(sync_w[1]), .err_cnt_o(err_w[1]));
    sample_merge #(.FRAME_LEN(64), .TIMEOUT(255), .MSB_FIRST(1'b0), .OFFSET_BIN(1'b0)) u2 (
        .clk(clk), .rst(rst), .start_i(start_i), .byte_i(byte_i), .byte_valid_i(byte_valid_i),
        .data_o(data_w[2]), .merge_finished_o(fin_w[2]), .in_sync_o(sync_w[2]), .err_cnt_o(err_w[2]));

    int n_chk = 0;
    int n_pass = 0;
    int pcount [ND];
    bit prev_fin [ND];
    bit armed = 1'b0;

    // Model: a frame is SYNC followed by FL pairs; a pair is two valid bytes
    int          m_mode [ND];
    bit          m_hf [ND];
    logic [7:0]  m_first [ND];
    int          m_idle [ND];
    int          m_cnt [ND];
    logic [15:0] e_data [ND];
    bit          e_pq [ND];
    int          e_err [ND];

    task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s u%0d: got %0h expected %0h at %0t", name, d, act, exp, $time);
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < ND; d++) begin
            if (armed) begin
                check("data_o", d, 32'(data_w[d]), 32'(e_data[d]));
                check("merge_finished_o", d, 32'(fin_w[d]), 32'(e_pq[d] && start_i));
                check("in_sync_o", d, 32'(sync_w[d]), 32'(m_mode[d] == M_FRAME));
                check("err_cnt_o", d, 32'(err_w[d]), 32'(e_err[d]));
                if (fin_w[d] === 1'b1) begin
                    check("no_adjacent_pulse", d, 32'(prev_fin[d]), 32'd0);
                    pcount[d]++;
                end
                prev_fin[d] = (fin_w[d] === 1'b1);
            end
            // advance model with the inputs the next posedge will sample
            if (rst) begin
                m_mode[d] = M_IDLE; m_hf[d] = 0; m_first[d] = 0; m_idle[d] = 0; m_cnt[d] = 0;
                e_data[d] = 0; e_pq[d] = 0; e_err[d] = 0;
            end else begin
                e_pq[d] = 0;
                if (!start_i) begin
                    m_mode[d] = M_IDLE; m_hf[d] = 0;
                end else if (m_mode[d] == M_IDLE) begin
                    m_mode[d] = M_HUNT;
                end else if (m_mode[d] == M_HUNT) begin
                    if (byte_valid_i && byte_i == 8'hA5) begin
                        m_mode[d] = M_FRAME; m_cnt[d] = 0; m_hf[d] = 0;
                    end
                end else if (m_mode[d] == M_FRAME) begin
                    if (!m_hf[d]) begin
                        if (byte_valid_i) begin
                            m_first[d] = byte_i; m_hf[d] = 1; m_idle[d] = 0;
                        end
                    end else if (byte_valid_i) begin
                        logic [15:0] raw;
                        raw = MSBF[d] ? {m_first[d], byte_i} : {byte_i, m_first[d]};
                        e_data[d] = OB[d] ? (raw ^ 16'h8000) : raw;
                        e_pq[d] = 1; m_hf[d] = 0; m_cnt[d]++;
                        if (m_cnt[d] == FL[d]) m_mode[d] = M_CHK;
                    end else if (m_idle[d] == TO[d] - 1) begin
                        m_mode[d] = M_HUNT; m_hf[d] = 0;
                        if (e_err[d] < 65535) e_err[d]++;
                    end else begin
                        m_idle[d]++;
                    end
                end else begin
                    if (byte_valid_i) begin
                        if (byte_i == 8'hA5) begin
                            m_mode[d] = M_FRAME; m_cnt[d] = 0; m_hf[d] = 0;
                        end else begin
                            m_mode[d] = M_HUNT;
                            if (e_err[d] < 65535) e_err[d]++;
                        end
                    end
                end
            end
        end
        if (rst) armed = 1'b1;
    end

    task automatic tick(input bit v, input logic [7:0] b);
        @(posedge clk); #1;
        byte_valid_i = v; byte_i = b;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 8'h00);
    endtask

    task automatic restart();
        @(posedge clk); #1; start_i = 1'b0; byte_valid_i = 1'b0;
        @(posedge clk); #1; start_i = 1'b1;
        @(posedge clk); #1;
    endtask

    int p0 [ND];
    int e0 [ND];

    task automatic snap();
        for (int d = 0; d < ND; d++) begin
            p0[d] = pcount[d]; e0[d] = int'(err_w[d]);
        end
    endtask

    initial begin
        for (int d = 0; d < ND; d++) begin
            pcount[d] = 0; prev_fin[d] = 0;
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("reset data_o", 0, 32'(data_w[0]), 32'h0);
        check("reset err_cnt_o", 0, 32'(err_w[0]), 32'h0);
        check("reset in_sync_o", 0, 32'(sync_w[0]), 32'h0);
        check("reset merge_finished_o", 0, 32'(fin_w[0]), 32'h0);

        // basic pair and frame of two followed by a good sync
        restart(); snap();
        tick(1, 8'hA5); tick(1, 8'h12); tick(1, 8'h34); tick(0, 8'h00);
        check("pulse 1clk after 2nd byte", 0, 32'(fin_w[0]), 32'h1);
        check("data 1234", 0, 32'(data_w[0]), 32'h1234);
        check("data offset 1234", 1, 32'(data_w[1]), 32'h9234);
        check("data lsb-first 1234", 2, 32'(data_w[2]), 32'h3412);
        tick(0, 8'h00);
        check("pulse one cycle", 0, 32'(fin_w[0]), 32'h0);
        tick(1, 8'h56); tick(1, 8'h78); tick(1, 8'hA5); tick(1, 8'h9A); tick(1, 8'hBC); idle(2);
        check("frame pulses", 0, 32'(pcount[0] - p0[0]), 32'd3);
        check("frame err", 0, 32'(int'(err_w[0]) - e0[0]), 32'd0);
        check("data 9ABC", 0, 32'(data_w[0]), 32'h9ABC);

        // bad sync after a full frame
        restart(); snap();
        tick(1, 8'hA5); tick(1, 8'h12); tick(1, 8'h34); tick(1, 8'h56); tick(1, 8'h78);
        tick(1, 8'h5A); idle(1);
        check("bad sync err", 0, 32'(int'(err_w[0]) - e0[0]), 32'd1);
        check("bad sync pulses", 0, 32'(pcount[0] - p0[0]), 32'd2);
        check("bad sync in_sync", 0, 32'(sync_w[0]), 32'h0);
        tick(1, 8'h11); tick(1, 8'h22); idle(1);
        check("hunt drops data", 0, 32'(sync_w[0]), 32'h0);
        tick(1, 8'hA5); idle(1);
        check("resync in_sync", 0, 32'(sync_w[0]), 32'h1);

        // offset binary conversion
        restart();
        tick(1, 8'hA5); tick(1, 8'h80); tick(1, 8'h00); tick(0, 8'h00);
        check("offset 8000", 1, 32'(data_w[1]), 32'h0000);
        tick(1, 8'hFF); tick(1, 8'hFF); tick(0, 8'h00);
        check("offset FFFF", 1, 32'(data_w[1]), 32'h7FFF);
        tick(1, 8'h00); tick(1, 8'h00); tick(0, 8'h00);
        check("offset 0000", 1, 32'(data_w[1]), 32'h8000);

        // timeout: TIMEOUT-1 idle cycles survive, TIMEOUT idle cycles abort
        restart(); snap();
        tick(1, 8'hA5); tick(1, 8'h11); idle(3); tick(1, 8'h22); tick(0, 8'h00);
        check("3 idle then pair", 0, 32'(fin_w[0]), 32'h1);
        check("data 1122", 0, 32'(data_w[0]), 32'h1122);
        tick(1, 8'h33); idle(4); tick(1, 8'h22); idle(2);
        check("timeout pulses", 0, 32'(pcount[0] - p0[0]), 32'd1);
        check("timeout err", 0, 32'(int'(err_w[0]) - e0[0]), 32'd1);
        check("timeout in_sync", 0, 32'(sync_w[0]), 32'h0);

        // back-to-back bytes
        restart(); snap();
        tick(1, 8'hA5);
        for (int i = 1; i <= 8; i++) tick(1, 8'(i));
        idle(2);
        check("b2b pulses", 2, 32'(pcount[2] - p0[2]), 32'd4);
        check("b2b data", 2, 32'(data_w[2]), 32'h0807);

        // start drop between bytes, with the second byte, and reset mid-pair
        restart(); snap();
        tick(1, 8'hA5); tick(1, 8'h12); tick(1, 8'h34); tick(1, 8'h56);
        @(posedge clk); #1; start_i = 1'b0; byte_valid_i = 1'b0;
        idle(2);
        check("drop pulses", 2, 32'(pcount[2] - p0[2]), 32'd1);
        check("drop holds data", 2, 32'(data_w[2]), 32'h3412);
        check("drop in_sync", 2, 32'(sync_w[2]), 32'h0);
        restart(); snap();
        tick(1, 8'hA5); tick(1, 8'h77);
        @(posedge clk); #1; start_i = 1'b0; byte_valid_i = 1'b1; byte_i = 8'h88;
        idle(2);
        check("start fall w/ byte", 2, 32'(pcount[2] - p0[2]), 32'd0);
        check("start fall data", 2, 32'(data_w[2]), 32'h3412);
        restart(); snap();
        tick(1, 8'hA5); tick(1, 8'h77);
        @(posedge clk); #1; rst = 1'b1; byte_valid_i = 1'b1; byte_i = 8'h88;
        @(posedge clk); #1; rst = 1'b0; byte_valid_i = 1'b0;
        idle(2);
        check("rst mid-pair pulses", 2, 32'(pcount[2] - p0[2]), 32'd0);
        check("rst data", 2, 32'(data_w[2]), 32'h0);
        check("rst in_sync", 2, 32'(sync_w[2]), 32'h0);

        // randomized stream, model checks every cycle
        for (int i = 0; i < 4000; i++) begin
            int vth;
            vth = ((i / 500) % 2 == 0) ? 85 : 45;
            @(posedge clk); #1;
            rst          = ($urandom_range(0, 699) == 0);
            start_i      = ($urandom_range(0, 149) != 0);
            byte_valid_i = ($urandom_range(0, 99) < vth);
            byte_i       = ($urandom_range(0, 3) == 0) ? 8'hA5 : 8'($urandom);
        end
        @(posedge clk); #1; rst = 1'b0; start_i = 1'b1; byte_valid_i = 1'b0;
        idle(3);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
